// File: rtl/usb_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_tx_pkg
// Description : Shared types and line encodings for the USB transmit path.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_tx_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DATA    = 3'd1,
        STUFF   = 3'd2,
        EOP_SE0 = 3'd3,
        EOP_J   = 3'd4
    } tx_line_state_t;

    // Line encodings as {d_plus, d_minus}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

endpackage : usb_tx_pkg
`default_nettype wire

// File: rtl/usb_tx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : usb_tx_bit_timer
// Description : Bit-period counter; tick marks the last clk of each period.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_tx_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= (r_count == c_last) ? '0 : r_count + 1'b1;
        end
    end

    assign tick = en && !clr && (r_count == c_last);

endmodule : usb_tx_bit_timer
`default_nettype wire

// File: rtl/usb_tx_line_encoder.sv
`default_nettype none
// ============================================================================
// Module      : usb_tx_line_encoder
// Description : Bit stuffing, NRZI encoding and EOP generation onto D+/D-.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_tx_line_encoder
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int STUFF_LEN    = 6,
    parameter int EOP_SE0_BITS = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic eop_req,
    input  logic serial_in,
    output logic shift_enable,
    output logic d_plus,
    output logic d_minus,
    output logic busy,
    output logic eop_done
);

    localparam int c_ones_w = $clog2(STUFF_LEN + 1);
    localparam int c_se0_w  = (EOP_SE0_BITS > 1) ? $clog2(EOP_SE0_BITS) : 1;
    localparam logic [c_ones_w-1:0] c_stuff_len = c_ones_w'(STUFF_LEN);
    localparam logic [c_se0_w-1:0]  c_se0_last  = c_se0_w'(EOP_SE0_BITS - 1);

    tx_line_state_t      r_state;
    logic [1:0]          r_line;
    logic                r_level;      // NRZI level: 1 = J, 0 = K
    logic [c_ones_w-1:0] r_ones;
    logic                r_eop_pend;
    logic [c_se0_w-1:0]  r_se0_cnt;

    logic                w_idle;
    logic                w_tick;
    logic                w_bit_level;
    logic [c_ones_w-1:0] w_ones_next;

    assign w_idle = (r_state == IDLE);

    usb_tx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_idle),
        .en   (!w_idle),
        .tick (w_tick)
    );

    assign w_bit_level = serial_in ? r_level : ~r_level;
    assign w_ones_next = serial_in ? r_ones + 1'b1 : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_line     <= LINE_J;
            r_level    <= 1'b1;
            r_ones     <= '0;
            r_eop_pend <= 1'b0;
            r_se0_cnt  <= '0;
        end else begin
            // Clearing on EOP_SE0 entry below takes precedence over a new request
            if (!w_idle && eop_req) r_eop_pend <= 1'b1;

            case (r_state)
                IDLE: begin
                    r_line <= LINE_J;
                    if (start) r_state <= DATA;
                end
                DATA: if (w_tick) begin
                    if (r_eop_pend) begin
                        r_state    <= EOP_SE0;
                        r_line     <= LINE_SE0;
                        r_eop_pend <= 1'b0;
                        r_se0_cnt  <= '0;
                    end else begin
                        r_level <= w_bit_level;
                        r_line  <= w_bit_level ? LINE_J : LINE_K;
                        r_ones  <= w_ones_next;
                        if (w_ones_next == c_stuff_len) r_state <= STUFF;
                    end
                end
                STUFF: if (w_tick) begin
                    r_level <= ~r_level;
                    r_line  <= r_level ? LINE_K : LINE_J;
                    r_ones  <= '0;
                    if (r_eop_pend) begin
                        r_state    <= EOP_SE0;
                        r_eop_pend <= 1'b0;
                        r_se0_cnt  <= '0;
                    end else begin
                        r_state <= DATA;
                    end
                end
                // Entered after a stuff bit, the line is not yet SE0: drive it
                // first, then count full SE0 periods.
                EOP_SE0: if (w_tick) begin
                    if (r_line != LINE_SE0) begin
                        r_line <= LINE_SE0;
                    end else if (r_se0_cnt == c_se0_last) begin
                        r_line  <= LINE_J;
                        r_state <= EOP_J;
                    end else begin
                        r_se0_cnt <= r_se0_cnt + 1'b1;
                    end
                end
                EOP_J: if (w_tick) begin
                    r_state <= IDLE;
                    r_level <= 1'b1;
                    r_ones  <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign shift_enable = (r_state == DATA) && w_tick && !r_eop_pend;
    assign eop_done     = (r_state == EOP_J) && w_tick;
    assign busy         = !w_idle;
    assign d_plus       = r_line[1];
    assign d_minus      = r_line[0];

endmodule : usb_tx_line_encoder
`default_nettype wire
